// File: rtl/reg_bank.sv
// reg_bank: small register bank with LOAD/CLEAR/INC/DEC and
// bit-serial shifts, one command at a time via i_valid/o_ready.
//
// Parameters:
//   WIDTH     data width of each register and of the data ports
//   NUM_REGS  number of registers (2..32)
//
// Ports:
//   i_clk      clock, all state changes on the rising edge
//   i_reset    asynchronous active-high reset
//   i_valid    command request
//   o_ready    bank can accept a command this cycle
//   i_op       opcode: 0 NOP, 1 LOAD, 2 CLEAR, 3 INC, 4 DEC,
//              5 SHL, 6 SHR (logical), 7 NOP
//   i_addr     target register
//   i_data     LOAD operand
//   i_shamt    shift amount, clamped to WIDTH
//   i_rd_addr  read-port address
//   o_rd_data  read-port data, 0 for addresses >= NUM_REGS
//   o_done     one-cycle completion pulse
//   o_err      one-cycle pulse with o_done for an illegal address
//   o_zero     result==0 of the last modifying command
//   o_carry    wrap/borrow/last shifted-out bit of that command
//
// Build option:
//   REG_BANK_FLAGS_EN  when defined, o_zero/o_carry are live;
//                      otherwise both are tied to 0.

module reg_bank #(
  parameter int WIDTH = 24,
  parameter int NUM_REGS = 8,
  localparam int ADDR_W = $clog2(NUM_REGS),
  localparam int SH_W = $clog2(WIDTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [SH_W-1:0]   i_shamt,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_done,
  output logic              o_err,
  output logic              o_zero,
  output logic              o_carry
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_DEC = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]  regs [NUM_REGS];
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              left_q, left_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_val;

  logic              cmd_ok;
  logic              rd_ok;
  logic [WIDTH-1:0]  cur;
  logic [WIDTH-1:0]  sh_cur;

  // Address legality: only a non-power-of-two bank has holes.
  if (NUM_REGS == (1 << ADDR_W)) begin : g_full
    assign cmd_ok = 1'b1;
    assign rd_ok  = 1'b1;
  end else begin : g_partial
    localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);
    assign cmd_ok = {1'b0, i_addr} < NREG;
    assign rd_ok  = {1'b0, i_rd_addr} < NREG;
  end

  assign cur       = cmd_ok ? regs[i_addr] : '0;
  assign sh_cur    = regs[tgt_q];
  assign o_rd_data = rd_ok ? regs[i_rd_addr] : '0;
  assign o_ready   = (state_q == S_IDLE);
  assign o_done    = done_q;
  assign o_err     = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    left_d  = left_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = i_addr;
    wr_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          done_d = 1'b1;
          if (!cmd_ok) begin
            err_d = 1'b1;
          end else begin
            unique case (i_op)
              OP_LOAD: begin
                wr_en  = 1'b1;
                wr_val = i_data;
              end
              OP_CLEAR: begin
                wr_en  = 1'b1;
                wr_val = '0;
              end
              OP_INC: begin
                wr_en  = 1'b1;
                wr_val = cur + WIDTH'(1);
              end
              OP_DEC: begin
                wr_en  = 1'b1;
                wr_val = cur - WIDTH'(1);
              end
              OP_SHL, OP_SHR: begin
                if (i_shamt == '0) begin
                  // zero shift completes like a write-back of itself
                  wr_en  = 1'b1;
                  wr_val = cur;
                end else begin
                  done_d  = 1'b0;
                  state_d = S_SHIFT;
                  tgt_d   = i_addr;
                  left_d  = (i_op == OP_SHL);
                  cnt_d   = (i_shamt > SH_W'(WIDTH))
                          ? SH_W'(WIDTH) : i_shamt;
                end
              end
              OP_NOP, OP_RSV: begin
              end
            endcase
          end
        end
      end
      S_SHIFT: begin
        wr_en   = 1'b1;
        wr_addr = tgt_q;
        wr_val  = left_q ? (sh_cur << 1) : (sh_cur >> 1);
        cnt_d   = cnt_q - SH_W'(1);
        if (cnt_q == SH_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      left_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      left_q  <= left_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_val;
    end
  end

`ifdef REG_BANK_FLAGS_EN
  logic fl_en;
  logic carry_d;
  logic zero_q;
  logic carry_q;

  // Flags move only when a modifying command completes: any
  // idle-state write, or the final step of a serial shift.
  assign fl_en = wr_en
               && (state_q == S_IDLE || cnt_q == SH_W'(1));

  always_comb begin
    carry_d = 1'b0;
    if (state_q == S_SHIFT) begin
      carry_d = left_q ? sh_cur[WIDTH-1] : sh_cur[0];
    end else if (i_op == OP_INC) begin
      carry_d = &cur;
    end else if (i_op == OP_DEC) begin
      carry_d = ~|cur;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (fl_en) begin
      zero_q  <= ~|wr_val;
      carry_q <= carry_d;
    end
  end

  assign o_zero  = zero_q;
  assign o_carry = carry_q;
`else
  assign o_zero  = 1'b0;
  assign o_carry = 1'b0;
`endif

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 24: data width of each register and of the data ports.
REQ-002 SHALL have parameter NUM_REGS, default 8: number of registers, range 2..32.
REQ-003 SHALL have derived localparams ADDR_W = clog2(NUM_REGS) and SH_W = clog2(WIDTH)+1.
REQ-004 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, 1: command request.
REQ-007 SHALL have port o_ready, output, 1: bank accepts a command this cycle.
REQ-008 SHALL have port i_op, input, 3: operation code.
REQ-009 SHALL have port i_addr, input, ADDR_W: target register.
REQ-010 SHALL have port i_data, input, WIDTH: LOAD operand.
REQ-011 SHALL have port i_shamt, input, SH_W: shift amount.
REQ-012 SHALL have port i_rd_addr, input, ADDR_W: read-port address.
REQ-013 SHALL have port o_rd_data, output, WIDTH: read-port data.
REQ-014 SHALL have port o_done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port o_err, output, 1: one-cycle pulse for an illegal address.
REQ-016 SHALL have ports o_zero and o_carry, output, 1 each: flags; see Configuration.

Function
REQ-017 SHALL accept a command on a rising edge where i_valid=1 and o_ready=1; i_op, i_addr, i_data and i_shamt are sampled on that edge.
REQ-018 SHALL decode ops: 000 NOP; 001 LOAD (reg=i_data); 010 CLEAR (reg=0); 011 INC (reg+1, mod 2^WIDTH); 100 DEC (reg-1, mod 2^WIDTH); 101 SHL by i_shamt; 110 SHR logical by i_shamt; 111 treated as NOP.
REQ-019 SHALL implement a two-state FSM: IDLE (o_ready=1) and SHIFT (o_ready=0).
REQ-020 SHALL, for NOP, LOAD, CLEAR, INC, DEC, and for SHL/SHR with i_shamt=0, update the register on the accept edge, stay in IDLE, and assert o_done in the following cycle.
REQ-021 SHALL, for SHL/SHR with i_shamt>0, go to SHIFT and load a counter with min(i_shamt, WIDTH).
REQ-022 SHALL, in SHIFT, shift the target register by one bit per cycle and decrement the counter.
REQ-023 SHALL, on the edge the counter reaches 0, return to IDLE and assert o_done in the following cycle, so a shift by n takes n cycles busy.
REQ-024 SHALL drive o_rd_data combinationally as regs[i_rd_addr]; during SHIFT it shows intermediate values.
REQ-025 SHALL, on a read of an address >= NUM_REGS, drive o_rd_data=0.
REQ-026 SHALL, for an accepted command with i_addr >= NUM_REGS, leave all registers unchanged and pulse o_err and o_done together one cycle later.
REQ-027 SHALL NOT produce a new o_done while another is pending; o_done and o_err are never asserted for more than one cycle per command.
REQ-028 SHALL ignore i_valid while o_ready=0; no command is queued.

Reset
REQ-029 SHALL, on i_reset=1 at any time including mid-SHIFT, immediately clear all registers, the counter, o_done, o_err, o_zero and o_carry, and put the FSM in IDLE (o_ready=1).
REQ-030 SHALL discard any shift interrupted by reset, with no o_done for it.

Configuration
REQ-031 SHALL use macro REG_BANK_FLAGS_EN to compile the flag logic in or out.
REQ-032 SHALL, when REG_BANK_FLAGS_EN is defined, register the flags on each register-modifying completion: o_zero = (result==0); o_carry = INC wrap from all-ones, DEC borrow from 0, or the last bit shifted out by SHL/SHR, otherwise 0.
REQ-033 SHALL hold o_zero and o_carry until the next modifying completion.
REQ-034 SHALL, when REG_BANK_FLAGS_EN is not defined, tie o_zero and o_carry to 0 and include no flag logic.

Verification
REQ-035 Reset, then LOAD r3=0x00ABCD, then i_rd_addr=3 -> o_rd_data=0x00ABCD; o_done pulses one cycle after accept.
REQ-036 LOAD r1=0xFFFFFF, then INC r1 -> r1=0; with flags enabled o_zero=1 and o_carry=1. Then DEC r1 -> 0xFFFFFF with o_carry=1.
REQ-037 LOAD r2=0x800001, SHL by 4 -> o_ready low for exactly 4 cycles; r2=0x000010; o_carry=0 (last bit out is bit 20 of the original, which is 0); i_valid during busy is ignored.
REQ-038 NUM_REGS=6, command to addr 7 -> registers unchanged, o_err=o_done=1 for one cycle; reading addr 7 -> 0.
REQ-039 SHR by 10 started, i_reset asserted after 3 cycles -> all registers 0, o_ready=1 immediately, no o_done.
REQ-040 Back-to-back INC on r0 every cycle for 5 cycles -> r0=5, five o_done pulses on consecutive cycles.
